// File: rtl/stream_arb_mux_pkg.sv
// stream_arb_mux shared types and helpers.
// Arbitration mode enum and channel-index width function.
package stream_arb_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Search starts at ptr and wraps; ptr = 0 gives fixed priority.
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int NUM_ELEM  = 6,
  parameter int SEL_WIDTH = sel_width(NUM_ELEM)
) (
  input  logic [NUM_ELEM-1:0]  req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [NUM_ELEM-1:0]  gnt,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  int c;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      c = (int'(ptr) + i) % NUM_ELEM;
      if (!any && req[SEL_WIDTH'(c)]) begin
        gnt[SEL_WIDTH'(c)] = 1'b1;
        idx = SEL_WIDTH'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered valid/ready N-to-1 arbitrating mux.
// Optional packet lock: define STREAM_ARB_MUX_LOCK_EN.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int ELEM_WIDTH  = 8,
  parameter int NUM_ELEM    = 6,
  parameter int ROUND_ROBIN = 1,
  parameter int SEL_WIDTH   = sel_width(NUM_ELEM)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] i_data_i,
  input  logic [NUM_ELEM-1:0]                 i_valid_i,
  output logic [NUM_ELEM-1:0]                 i_ready_o,
`ifdef STREAM_ARB_MUX_LOCK_EN
  input  logic [NUM_ELEM-1:0]                 i_last_i,
  output logic                                o_last_o,
`endif
  output logic [ELEM_WIDTH-1:0]               o_data_o,
  output logic [SEL_WIDTH-1:0]                o_sel_o,
  output logic                                o_valid_o,
  input  logic                                o_ready_i
);

  localparam arb_mode_e MODE =
    (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;

  logic                 load;
  logic                 xfer;
  logic [NUM_ELEM-1:0]  req;
  logic [NUM_ELEM-1:0]  gnt;
  logic [SEL_WIDTH-1:0] idx;
  logic                 any;
  logic [SEL_WIDTH-1:0] ptr;

  assign load = ~o_valid_o | o_ready_i;

`ifdef STREAM_ARB_MUX_LOCK_EN
  logic                 lock_q;
  logic [SEL_WIDTH-1:0] lock_idx_q;
  logic [NUM_ELEM-1:0]  lock_mask;

  // while locked only the owning channel may request
  always_comb begin
    lock_mask = '0;
    lock_mask[lock_idx_q] = 1'b1;
    req = lock_q ? (i_valid_i & lock_mask) : i_valid_i;
  end
`else
  assign req = i_valid_i;
`endif

  rr_arbiter #(
    .NUM_ELEM  (NUM_ELEM),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign i_ready_o = (rst_ni && load) ? gnt : '0;
  assign xfer      = any & load & rst_ni;

  if (MODE == ARB_RR) begin : g_rr
    logic [SEL_WIDTH-1:0] ptr_q;

    // pointer moves past the channel just served
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        ptr_q <= '0;
      end else if (xfer) begin
        if (idx == SEL_WIDTH'(NUM_ELEM - 1))
          ptr_q <= '0;
        else
          ptr_q <= idx + 1'b1;
      end
    end

    assign ptr = ptr_q;
  end else begin : g_fixed
    assign ptr = '0;
  end

  // output pipeline register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      o_valid_o <= 1'b0;
      o_data_o  <= '0;
      o_sel_o   <= '0;
    end else if (load) begin
      if (xfer) begin
        o_valid_o <= 1'b1;
        o_data_o  <= i_data_i[idx];
        o_sel_o   <= idx;
      end else begin
        o_valid_o <= 1'b0;
      end
    end
  end

`ifdef STREAM_ARB_MUX_LOCK_EN
  // packet lock and last flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      o_last_o   <= 1'b0;
    end else if (xfer) begin
      lock_q     <= ~i_last_i[idx];
      lock_idx_q <= idx;
      o_last_o   <= i_last_i[idx];
    end
  end
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux.
// Round-robin and fixed-priority instances side by side.
module tb_stream_arb_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [5:0][7:0] rr_data;
  logic [5:0]      rr_valid;
  logic [5:0]      rr_rdy;
  logic [7:0]      rr_odata;
  logic [2:0]      rr_osel;
  logic            rr_ovalid;
  logic            rr_oready;
`ifdef STREAM_ARB_MUX_LOCK_EN
  logic [5:0]      rr_last;
  logic            rr_olast;
  logic [5:0]      fp_last;
  logic            fp_olast;
`endif

  logic [5:0][7:0] fp_data;
  logic [5:0]      fp_valid;
  logic [5:0]      fp_rdy;
  logic [7:0]      fp_odata;
  logic [2:0]      fp_osel;
  logic            fp_ovalid;
  logic            fp_oready;

  int total = 0;
  int bad = 0;

  stream_arb_mux #(
    .ELEM_WIDTH  (8),
    .NUM_ELEM    (6),
    .ROUND_ROBIN (1)
  ) u_rr (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .i_data_i  (rr_data),
    .i_valid_i (rr_valid),
    .i_ready_o (rr_rdy),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .i_last_i  (rr_last),
    .o_last_o  (rr_olast),
`endif
    .o_data_o  (rr_odata),
    .o_sel_o   (rr_osel),
    .o_valid_o (rr_ovalid),
    .o_ready_i (rr_oready)
  );

  stream_arb_mux #(
    .ELEM_WIDTH  (8),
    .NUM_ELEM    (6),
    .ROUND_ROBIN (0)
  ) u_fp (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .i_data_i  (fp_data),
    .i_valid_i (fp_valid),
    .i_ready_o (fp_rdy),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .i_last_i  (fp_last),
    .o_last_o  (fp_olast),
`endif
    .o_data_o  (fp_odata),
    .o_sel_o   (fp_osel),
    .o_valid_o (fp_ovalid),
    .o_ready_i (fp_oready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      rr_data[k] = 8'hA0 + 8'(k);
      fp_data[k] = 8'h00;
    end
    rr_valid  = 6'h3f;
    rr_oready = 1'b1;
    fp_valid  = '0;
    fp_oready = 1'b1;
`ifdef STREAM_ARB_MUX_LOCK_EN
    rr_last = '0;
    fp_last = '0;
`endif

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(rr_ovalid), 0);
    chk("rst_data", 32'(rr_odata), 0);
    chk("rst_sel", 32'(rr_osel), 0);
    chk("rst_ready", 32'(rr_rdy), 0);

    // round-robin fairness, all channels valid
    rst_n = 1'b1;
    #1;
    chk("rr_rdy0", 32'(rr_rdy), 32'h01);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_sel", 32'(rr_osel), 32'(k));
      chk("rr_data", 32'(rr_odata), 32'h0A0 + 32'(k));
      chk("rr_valid", 32'(rr_ovalid), 1);
      chk("rr_rdy", 32'(rr_rdy), 32'(1 << ((k + 1) % 6)));
    end

    // backpressure with word 5A from channel 3
    rr_valid   = 6'b001000;
    rr_data[3] = 8'h5A;
    rr_data[4] = 8'h77;
    rr_data[1] = 8'h11;
    tick();
    chk("bp_cap_sel", 32'(rr_osel), 3);
    chk("bp_cap_data", 32'(rr_odata), 32'h5A);
    rr_oready = 1'b0;
    rr_valid  = 6'b010010;
    #1;
    chk("bp_rdy_comb", 32'(rr_rdy), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_data", 32'(rr_odata), 32'h5A);
      chk("bp_sel", 32'(rr_osel), 3);
      chk("bp_valid", 32'(rr_ovalid), 1);
      chk("bp_rdy", 32'(rr_rdy), 0);
    end
    rr_oready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(rr_rdy), 32'b010000);
    tick();
    chk("bp_next_sel", 32'(rr_osel), 4);
    chk("bp_next_data", 32'(rr_odata), 32'h77);
    rr_valid = 6'b000010;
    tick();
    chk("bp_then_sel", 32'(rr_osel), 1);
    chk("bp_then_data", 32'(rr_odata), 32'h11);

    // single transfer from channel 5, then idle
    rr_valid   = 6'b100000;
    rr_data[5] = 8'hC5;
    tick();
    chk("wr_sel", 32'(rr_osel), 5);
    chk("wr_valid", 32'(rr_ovalid), 1);
    rr_valid = '0;
    tick();
    chk("idle_valid", 32'(rr_ovalid), 0);
    chk("idle_data", 32'(rr_odata), 32'hC5);
    chk("idle_sel", 32'(rr_osel), 5);
    tick();
    rr_valid = 6'b100001;
    #1;
    chk("wrap_rdy", 32'(rr_rdy), 32'b000001);
    tick();
    chk("wrap_sel", 32'(rr_osel), 0);
    chk("wrap_data", 32'(rr_odata), 32'hA0);
    rr_valid = '0;
    tick();
    chk("wrap_idle", 32'(rr_ovalid), 0);

    // reset mid-transfer
    rr_valid = 6'h3f;
    tick();
    chk("mid_valid", 32'(rr_ovalid), 1);
    chk("mid_sel", 32'(rr_osel), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(rr_rdy), 0);
    tick();
    chk("mid_rst_valid", 32'(rr_ovalid), 0);
    chk("mid_rst_sel", 32'(rr_osel), 0);
    chk("mid_rst_data", 32'(rr_odata), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(rr_rdy), 32'b000001);
    tick();
    chk("post_rst_sel", 32'(rr_osel), 0);
    chk("post_rst_data", 32'(rr_odata), 32'hA0);

`ifdef STREAM_ARB_MUX_LOCK_EN
    // 3-beat packet on channel 1 blocks channel 0
    rr_valid   = 6'b000011;
    rr_data[1] = 8'hB1;
    rr_last    = 6'b000000;
    #1;
    chk("lk_rdy1", 32'(rr_rdy), 32'b000010);
    tick();
    chk("lk_sel1", 32'(rr_osel), 1);
    chk("lk_data1", 32'(rr_odata), 32'hB1);
    chk("lk_last1", 32'(rr_olast), 0);
    rr_data[1] = 8'hB2;
    #1;
    chk("lk_rdy2", 32'(rr_rdy), 32'b000010);
    tick();
    chk("lk_sel2", 32'(rr_osel), 1);
    chk("lk_last2", 32'(rr_olast), 0);
    rr_data[1] = 8'hB3;
    rr_last    = 6'b000010;
    #1;
    chk("lk_rdy3", 32'(rr_rdy), 32'b000010);
    tick();
    chk("lk_sel3", 32'(rr_osel), 1);
    chk("lk_data3", 32'(rr_odata), 32'hB3);
    chk("lk_last3", 32'(rr_olast), 1);
    rr_valid = 6'b000001;
    rr_last  = '0;
    #1;
    chk("lk_rdy_rel", 32'(rr_rdy), 32'b000001);
    tick();
    chk("lk_sel_rel", 32'(rr_osel), 0);
    chk("lk_last_rel", 32'(rr_olast), 0);
`endif
    rr_valid = '0;
    tick();

    // fixed priority: channels 2 and 4
    fp_data[2] = 8'h22;
    fp_data[4] = 8'h44;
    fp_valid   = 6'b010100;
    #1;
    chk("fp_rdy2", 32'(fp_rdy), 32'b000100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_sel2", 32'(fp_osel), 2);
      chk("fp_data2", 32'(fp_odata), 32'h22);
    end
    fp_valid = 6'b010000;
    #1;
    chk("fp_rdy4", 32'(fp_rdy), 32'b010000);
    tick();
    chk("fp_sel4", 32'(fp_osel), 4);
    chk("fp_data4", 32'(fp_odata), 32'h44);
    fp_valid = '0;
    tick();
    chk("fp_idle", 32'(fp_ovalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
